// File: rtl/producer2riscv_if.sv
// Stream bundle between producer2riscv and its two neighbours: producer side
// (din/val_in/ready_upward) and RISC-V side (dout/val_out/ready_downward).
interface producer2riscv_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
);
  logic [DATA_WIDTH-1:0]  din;
  logic                   val_in;
  logic                   ready_upward;
  logic [DATA_WIDTH-1:0]  dout;
  logic                   val_out;
  logic                   ready_downward;
  logic [$clog2(DEPTH):0] level;
  logic                   almost_full;

  modport master (
    output din, val_in, ready_downward,
    input  ready_upward, dout, val_out, level, almost_full
  );

  modport slave (
    input  din, val_in, ready_downward,
    output ready_upward, dout, val_out, level, almost_full
  );
endinterface

// File: rtl/producer2riscv.sv
// Producer-to-PicoRV32 input adapter: first-word-fall-through FIFO with fully
// registered ready/valid. Define PRODUCER2RISCV_LEVEL_EN for level/almost_full.
module producer2riscv #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 8,
  parameter int AFULL_MARGIN = 2
) (
  input  logic             clk,
  input  logic             reset,
  producer2riscv_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AFULL_MARGIN < 0 || AFULL_MARGIN > DEPTH) begin : g_bad_cfg
    $error("producer2riscv: DEPTH must be a power of two >= 2 and 0 <= AFULL_MARGIN <= DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic                  full;
  logic                  empty;
  logic                  ready;
  logic                  valid;
  logic                  push;
  logic                  pop;

  // Handshake outputs come from registers only, so nothing on the RISC-V side
  // reaches ready_upward combinationally.
  always_comb begin
    ready     = ~full & ~reset;
    valid     = ~empty & ~reset;
    push      = bus.val_in & ready;
    pop       = valid & bus.ready_downward;
    count_nxt = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.din;
  end

  always_comb begin
    bus.ready_upward = ready;
    bus.val_out      = valid;
    bus.dout         = valid ? mem[rd_ptr] : '0;
  end

`ifdef PRODUCER2RISCV_LEVEL_EN
  logic afull;

  always_ff @(posedge clk) begin
    if (reset) afull <= 1'b0;
    else       afull <= (count_nxt >= CW'(DEPTH - AFULL_MARGIN));
  end

  // count is cleared by the same reset edge; gating keeps the flags at 0 for
  // the whole reset cycle, including the first one.
  always_comb begin
    bus.level       = reset ? '0 : count;
    bus.almost_full = afull & ~reset;
  end
`else
  always_comb begin
    bus.level       = '0;
    bus.almost_full = 1'b0;
  end
`endif
endmodule

// File: tb/tb_producer2riscv.sv
// Self-checking bench for producer2riscv: directed vector table, corner-case
// sequences and random traffic against a queue-based reference model.
module tb_producer2riscv;
  localparam int DW     = 32;
  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;

  logic clk;
  logic reset;

  producer2riscv_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  producer2riscv #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .AFULL_MARGIN(MARGIN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned vectors  = 0;
  int unsigned errors   = 0;
  int unsigned pushed   = 0;
  logic [DW-1:0] q[$];

  typedef struct {
    logic          rst;
    logic          val;
    logic [DW-1:0] din;
    logic          rdy;
    logic          e_ready;
    logic          e_val;
    logic [DW-1:0] e_dout;
    int unsigned   e_level;
  } vec_t;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a word enters when val_in meets a non-full queue, leaves
  // when ready_downward meets a non-empty queue; reset empties it.
  task automatic model_step(input logic r, input logic [DW-1:0] d, input logic v, input logic rd);
    bit do_push, do_pop;
    if (r) begin
      q.delete();
    end else begin
      do_pop  = rd && (q.size() > 0);
      do_push = v && (q.size() < DEPTH);
      if (do_pop)  void'(q.pop_front());
      if (do_push) begin
        q.push_back(d);
        pushed++;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic [DW-1:0] d, input logic v, input logic rd);
    logic e_val;
    reset = r; bus.din = d; bus.val_in = v; bus.ready_downward = rd;
    #1;
    e_val = !r && (q.size() > 0);
    chk("ready_upward", DW'(bus.ready_upward), DW'(!r && (q.size() < DEPTH)));
    chk("val_out", DW'(bus.val_out), DW'(e_val));
    chk("dout", bus.dout, e_val ? q[0] : '0);
`ifdef PRODUCER2RISCV_LEVEL_EN
    chk("level", DW'(bus.level), r ? '0 : DW'(q.size()));
    chk("almost_full", DW'(bus.almost_full), DW'(!r && (q.size() >= DEPTH - MARGIN)));
`else
    chk("level", DW'(bus.level), '0);
    chk("almost_full", DW'(bus.almost_full), '0);
`endif
    model_step(r, d, v, rd);
    @(negedge clk);
  endtask

  vec_t tbl[$];

  initial begin
    vec_t t;
    int unsigned budget;

    reset = 1'b1; bus.din = '0; bus.val_in = 1'b0; bus.ready_downward = 1'b0;

    // Directed vectors: outputs are those seen during the cycle, before its edge.
    tbl.push_back('{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         0});
    tbl.push_back('{1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h0,         0});
    tbl.push_back('{1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0, 32'h0,         0});
    tbl.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hA5A5_0001, 1});
    tbl.push_back('{1'b0, 1'b1, 32'hA5A5_0002, 1'b1, 1'b1, 1'b1, 32'hA5A5_0001, 1});
    tbl.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hA5A5_0002, 1});
    tbl.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'hA5A5_0002, 1});
    tbl.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         0});

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      reset = t.rst; bus.din = t.din; bus.val_in = t.val; bus.ready_downward = t.rdy;
      #1;
      chk("tbl_ready", DW'(bus.ready_upward), DW'(t.e_ready));
      chk("tbl_val", DW'(bus.val_out), DW'(t.e_val));
      chk("tbl_dout", bus.dout, t.e_dout);
`ifdef PRODUCER2RISCV_LEVEL_EN
      chk("tbl_level", DW'(bus.level), DW'(t.e_level));
`else
      chk("tbl_level", DW'(bus.level), '0);
`endif
      model_step(t.rst, t.din, t.val, t.rdy);
      @(negedge clk);
    end

    // Fill to full, then hold a 9th word against a full buffer.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h1000 + DW'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)     cycle(1'b0, 32'h1008, 1'b1, 1'b0);
    // Pop with val_in high while full: no push this cycle, ready next cycle.
    cycle(1'b0, 32'h1008, 1'b1, 1'b1);
    cycle(1'b0, 32'h1008, 1'b1, 1'b0);
    chk("held_word_accepted", DW'(q[DEPTH-1]), 32'h1008);
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b0, 1'b1);

    // Streaming 0..19 with both sides always ready: wraps the pointers twice.
    cycle(1'b1, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, DW'(i), 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Random traffic until 1000 more words are accepted.
    pushed = 0;
    budget = 0;
    while (pushed < 1000 && budget < 20000) begin
      cycle(1'b0, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      budget++;
    end
    chk("random_words_done", DW'(pushed >= 1000), 32'd1);
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, '0, 1'b0, 1'b1);

    // Reset with 5 words buffered: all discarded, new word is first out.
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h5000 + DW'(i), 1'b1, 1'b0);
    cycle(1'b1, '0, 1'b0, 1'b0);
    cycle(1'b0, 32'h1234, 1'b1, 1'b0);
    chk("post_reset_head", bus.dout, 32'h1234);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
